// File: rtl/stack_port_arbiter.sv
// ---------------------------------------------------------------------------
// stack_port_arbiter
//
// Shares port A of the stack memory between the register-fetch stage of the
// pipeline and a debug/loader host. The pipeline normally owns the port. The
// host is granted when the pipeline is idle, or when the host has waited
// starve_limit cycles, in which case the pipeline is stalled for one cycle.
//
// Host handshake: the host raises host_req and holds host_we, host_adr and
// host_wdata stable until it sees host_ack. host_ack is a one-cycle pulse in
// the cycle after the grant. host_rdata is valid only while host_ack is high.
// The host may drop or change host_req in the cycle after host_ack. Only one
// host access is outstanding at a time, so accesses complete in order.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   pipe_en, pipe_adr   register-fetch read request (port A)
//   pipe_stall          stalls the pipeline during a forced host grant
//   host_req, host_we   host access request and direction (1 = write)
//   host_adr            host address
//   host_wdata          host write data
//   host_ack            one-cycle completion pulse
//   host_rdata          host read data (0 for writes)
//   mem_en, mem_we      port A enable / write strobe
//   mem_adr, mem_wdata  port A address / write data
//   mem_rdata           port A read data, one cycle after mem_en
//   grant_count         number of host grants, wrapping at 16 bits
//   dbg_state           FSM state (0 = S_PIPE, 1 = S_ACK)
//   dbg_wait_cnt        current host wait counter
// ---------------------------------------------------------------------------
module stack_port_arbiter #(
    parameter int data_mem_size_in_bits = 30,
    parameter int starve_limit          = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pipe_en,
    input  logic [data_mem_size_in_bits-1:0] pipe_adr,
    output logic                             pipe_stall,
    input  logic                             host_req,
    input  logic                             host_we,
    input  logic [data_mem_size_in_bits-1:0] host_adr,
    input  logic [31:0]                      host_wdata,
    output logic                             host_ack,
    output logic [31:0]                      host_rdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [data_mem_size_in_bits-1:0] mem_adr,
    output logic [31:0]                      mem_wdata,
    input  logic [31:0]                      mem_rdata,
    output logic [15:0]                      grant_count,
    output logic                             dbg_state,
    output logic [7:0]                       dbg_wait_cnt
);

    typedef enum logic {
        S_PIPE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    localparam logic [7:0] STARVE = 8'(starve_limit);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        ack_we;      // direction of the access being acknowledged
    logic [15:0] grant_cnt_q;
    logic        grant_host;

    // rst is folded in so that no grant is visible while reset is held,
    // even though the state register already reads S_PIPE.
    assign grant_host = rst & host_req & (state == S_PIPE) &
                        (~pipe_en | (wait_cnt == STARVE));

    // Port A steering.
    always_comb begin
        mem_en    = pipe_en;
        mem_we    = 1'b0;
        mem_adr   = pipe_adr;
        mem_wdata = 32'h0;
        if (grant_host) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_adr   = host_adr;
            mem_wdata = host_wdata;
        end
    end

    // Only a forced grant takes a cycle away from an active pipeline read.
    assign pipe_stall = grant_host & pipe_en;

    // The ack cycle is exactly the cycle in which the granted read returns
    // from the synchronous memory, so the read data passes straight through.
    assign host_ack   = (state == S_ACK);
    assign host_rdata = (state == S_ACK && !ack_we) ? mem_rdata : 32'h0;

    assign grant_count  = grant_cnt_q;
    assign dbg_state    = (state == S_ACK);
    assign dbg_wait_cnt = wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_PIPE;
            wait_cnt    <= 8'h0;
            ack_we      <= 1'b0;
            grant_cnt_q <= 16'h0;
        end else begin
            case (state)
                S_PIPE: begin
                    if (grant_host) begin
                        state  <= S_ACK;
                        ack_we <= host_we;
                    end
                end
                S_ACK: begin
                    state <= S_PIPE;
                end
                default: begin
                    state <= S_PIPE;
                end
            endcase

            // Wait counter measures how long the current request has been
            // refused; it stops at the limit so the grant condition holds.
            if (!host_req || grant_host) begin
                wait_cnt <= 8'h0;
            end else if (wait_cnt != STARVE) begin
                wait_cnt <= wait_cnt + 8'h1;
            end

            if (grant_host) begin
                grant_cnt_q <= grant_cnt_q + 16'h1;
            end
        end
    end

endmodule

// File: tb/tb_stack_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stack_port_arbiter
//
// Bench for stack_port_arbiter. A small synchronous memory model sits on
// port A. Expected host read data comes from a separate reference array that
// the bench updates when it issues host writes; it is queued at issue time
// and compared whenever host_ack is seen.
// ---------------------------------------------------------------------------
module tb_stack_port_arbiter;

    localparam int AW = 30;
    localparam int SL = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          pipe_en = 1'b0;
    logic [AW-1:0] pipe_adr = '0;
    logic          pipe_stall;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_adr = '0;
    logic [31:0]   host_wdata = 32'h0;
    logic          host_ack;
    logic [31:0]   host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;
    logic [15:0]   grant_count;
    logic          dbg_state;
    logic [7:0]    dbg_wait_cnt;

    stack_port_arbiter #(
        .data_mem_size_in_bits(AW),
        .starve_limit(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_en(pipe_en),
        .pipe_adr(pipe_adr),
        .pipe_stall(pipe_stall),
        .host_req(host_req),
        .host_we(host_we),
        .host_adr(host_adr),
        .host_wdata(host_wdata),
        .host_ack(host_ack),
        .host_rdata(host_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_adr(mem_adr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .grant_count(grant_count),
        .dbg_state(dbg_state),
        .dbg_wait_cnt(dbg_wait_cnt)
    );

    // ---------------- memory model and reference ----------------
    logic [31:0] mem_store [0:255];
    logic [31:0] ref_mem   [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_store[mem_adr[7:0]] = mem_wdata;
            else        mem_rdata <= mem_store[mem_adr[7:0]];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (rst && host_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check("host_rdata", host_rdata, exp_v);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one host access and waits (bounded) for its grant and ack.
    task automatic host_op(input logic we, input logic [7:0] adr,
                           input logic [31:0] wd, input bit rand_pipe);
        int waited;
        bit done;
        host_req   = 1'b1;
        host_we    = we;
        host_adr   = {22'h0, adr};
        host_wdata = wd;
        if (we) begin
            ref_mem[adr] = wd;
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(ref_mem[adr]);
        end
        waited = 0;
        done   = 1'b0;
        while (!done && waited <= 300) begin
            if (rand_pipe) begin
                pipe_en  = 1'($urandom_range(0, 1));
                pipe_adr = AW'($urandom_range(0, 255));
            end
            tick();
            if (dbg_state) done = 1'b1;
            else           waited++;
        end
        check("host_grant_timeout", 32'(done), 32'd1);
        if (done) begin
            check("ack_wait_bound", 32'(waited <= SL), 32'd1);
            check("ack_pulse", 32'(host_ack), 32'd1);
        end
        tick();
        host_req = 1'b0;
        pipe_en  = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem_store[i] = v;
            ref_mem[i]   = v;
        end
        mem_store[8'h40] = 32'hDEADBEEF;
        ref_mem[8'h40]   = 32'hDEADBEEF;

        // Reset: pipeline passes through, no grant even with host_req high.
        #12;
        pipe_en    = 1'b1;
        pipe_adr   = 30'h7;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_adr   = 30'h40;
        host_wdata = 32'hA5A5A5A5;
        #1;
        check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_adr", 32'(mem_adr), 32'h7);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_host_rdata", host_rdata, 32'h0);
        check("rst_grant_count", 32'(grant_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
        host_req = 1'b0;
        host_we  = 1'b0;
        pipe_en  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Idle grant, with the request held across the ack cycle.
        host_req = 1'b1;
        host_we  = 1'b0;
        host_adr = 30'h40;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        check("idle_mem_en", 32'(mem_en), 32'd1);
        check("idle_mem_adr", 32'(mem_adr), 32'h40);
        check("idle_stall", 32'(pipe_stall), 32'd0);
        check("idle_ack_early", 32'(host_ack), 32'd0);
        tick();
        check("idle_ack", 32'(host_ack), 32'd1);
        check("idle_count", 32'(grant_count), 32'd1);
        check("held_no_grant", 32'(mem_en), 32'd0);
        check("held_no_stall", 32'(pipe_stall), 32'd0);
        tick();
        check("held_regrant", 32'(mem_en), 32'd1);
        check("held_state", 32'(dbg_state), 32'd0);
        check("held_ack_low", 32'(host_ack), 32'd0);
        tick();
        check("held_ack2", 32'(host_ack), 32'd1);
        check("held_count", 32'(grant_count), 32'd2);
        tick();
        host_req = 1'b0;
        #1;
        check("idle_release_en", 32'(mem_en), 32'd0);
        tick();

        // Write then read the same address.
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_adr   = 30'h80;
        host_wdata = 32'h12345678;
        ref_mem[8'h80] = 32'h12345678;
        exp_q.push_back(32'h0);
        #1;
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_adr", 32'(mem_adr), 32'h80);
        check("wr_mem_wdata", mem_wdata, 32'h12345678);
        tick();
        check("wr_ack", 32'(host_ack), 32'd1);
        check("wr_ack_mem_we", 32'(mem_we), 32'd0);
        tick();
        host_we = 1'b0;
        exp_q.push_back(32'h12345678);
        #1;
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_adr", 32'(mem_adr), 32'h80);
        tick();
        check("rd_ack", 32'(host_ack), 32'd1);
        tick();
        host_req = 1'b0;
        tick();

        // Starvation: pipeline busy every cycle.
        pipe_en  = 1'b1;
        pipe_adr = 30'h11;
        host_req = 1'b1;
        host_we  = 1'b0;
        host_adr = 30'h40;
        exp_q.push_back(32'hDEADBEEF);
        for (int i = 0; i < SL; i++) begin
            #1;
            check("starve_no_stall", 32'(pipe_stall), 32'd0);
            check("starve_pipe_adr", 32'(mem_adr), 32'h11);
            check("starve_wait_cnt", 32'(dbg_wait_cnt), 32'(i));
            tick();
        end
        check("starve_stall", 32'(pipe_stall), 32'd1);
        check("starve_host_adr", 32'(mem_adr), 32'h40);
        check("starve_wait_max", 32'(dbg_wait_cnt), 32'(SL));
        tick();
        check("starve_ack", 32'(host_ack), 32'd1);
        check("starve_ack_stall", 32'(pipe_stall), 32'd0);
        check("starve_ack_adr", 32'(mem_adr), 32'h11);
        check("starve_wait_clr", 32'(dbg_wait_cnt), 32'd0);
        check("starve_count", 32'(grant_count), 32'd5);
        tick();
        host_req = 1'b0;
        pipe_en  = 1'b0;
        tick();

        // Random host traffic against random pipeline activity.
        for (int i = 0; i < 10; i++) begin
            host_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    $urandom, 1'b1);
        end
        check("random_count", 32'(grant_count), 32'd15);

        // Reset asserted during the ack cycle.
        host_req = 1'b1;
        host_we  = 1'b0;
        host_adr = 30'h40;
        tick();
        check("rstmid_in_ack", 32'(host_ack), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_ack_drop", 32'(host_ack), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'd0);
        check("rstmid_count", 32'(grant_count), 32'd0);
        check("rstmid_rdata", host_rdata, 32'h0);
        @(negedge clk);
        host_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rstrel_state", 32'(dbg_state), 32'd0);
        check("rstrel_ack", 32'(host_ack), 32'd0);
        check("rstrel_count", 32'(grant_count), 32'd0);

        // Counter wrap.
        force dut.grant_cnt_q = 16'hFFFF;
        #1;
        release dut.grant_cnt_q;
        #1;
        check("wrap_preset", 32'(grant_count), 32'hFFFF);
        host_op(1'b0, 8'h40, 32'h0, 1'b0);
        check("wrap_count", 32'(grant_count), 32'h0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_port_arbiter.md
STACK_PORT_ARBITER -- requirements
Module: stack_port_arbiter

Interface
REQ-001 The module SHALL have parameter data_mem_size_in_bits, default 30, giving the width of the stack-memory word address.
REQ-002 The module SHALL have parameter starve_limit, default 8, giving the host wait-cycle count that forces a grant (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 pipe_en  input  1  read request on port A from the register-fetch stage (its mem_enable_a).
REQ-006 pipe_adr  input  data_mem_size_in_bits  register-fetch read address (its mem_adr_a).
REQ-007 pipe_stall  output  1  high stalls the pipeline; ORed into stallexe outside this block.
REQ-008 host_req  input  1  debug/loader access request; held until host_ack.
REQ-009 host_we  input  1  1 = write, 0 = read; stable while host_req is high.
REQ-010 host_adr  input  data_mem_size_in_bits  host address; stable while host_req is high.
REQ-011 host_wdata  input  32  host write data.
REQ-012 host_ack  output  1  one-cycle completion pulse.
REQ-013 host_rdata  output  32  read data; valid while host_ack is high.
REQ-014 mem_en, mem_we  output  1 each  port A enable and write strobe.
REQ-015 mem_adr  output  data_mem_size_in_bits  port A address.
REQ-016 mem_wdata  output  32  port A write data.
REQ-017 mem_rdata  input  32  port A read data, synchronous, one cycle after mem_en.
REQ-018 grant_count  output  16  number of host grants, wrapping.

Function
REQ-019 The FSM SHALL have two states: S_PIPE (port owned by pipeline, host grant possible) and S_ACK (host completion cycle).
REQ-020 grant_host SHALL be combinational: host_req AND state==S_PIPE AND (NOT pipe_en OR wait_cnt==starve_limit).
REQ-021 When grant_host=0: mem_en=pipe_en, mem_we=0, mem_adr=pipe_adr, mem_wdata=0.
REQ-022 When grant_host=1: mem_en=1, mem_we=host_we, mem_adr=host_adr, mem_wdata=host_wdata.
REQ-023 pipe_stall SHALL be grant_host AND pipe_en: a forced grant stalls exactly one cycle, with no combinational path from host_rdata.
REQ-024 On grant_host the state SHALL go to S_ACK; in S_ACK host_ack=1, host_rdata=mem_rdata for reads and 0 for writes, and the state SHALL return to S_PIPE next cycle.
REQ-025 In S_ACK the pipeline SHALL own the port per REQ-021 and no host grant SHALL occur; the host drops or changes host_req the cycle after host_ack.
REQ-026 wait_cnt (8 bit) SHALL increment when host_req=1 and grant_host=0, saturate at starve_limit, and clear to 0 on grant_host or host_req=0.
REQ-027 grant_count SHALL increment by 1 on each grant_host cycle and wrap from 0xFFFF to 0.
REQ-028 Back-to-back host accesses SHALL complete at most one per two cycles (grant, ack).
REQ-029 Host accesses SHALL complete in order, one outstanding at a time; a read issued while pipe_en=0 SHALL complete with zero pipeline stall.

Reset
REQ-030 While rst=0: state=S_PIPE, wait_cnt=0, host_ack=0, host_rdata=0, grant_count=0.
REQ-031 While rst=0, combinational outputs SHALL follow REQ-021 with no grant (pipe_stall=0).
REQ-032 Reset asserted in S_ACK SHALL drop host_ack immediately, with no further ack for that access; the host reissues it after reset.
REQ-033 Reset deassertion SHALL be synchronised to clk outside this block; the first edge after release SHALL behave as S_PIPE.

Verification
REQ-034 Idle grant: pipe_en=0, host read of adr 0x40 holding 0xDEADBEEF -> mem_en=1, mem_adr=0x40 in the grant cycle; next cycle host_ack=1, host_rdata=0xDEADBEEF; pipe_stall never 1; grant_count=1.
REQ-035 Starvation: pipe_en=1 continuously, host_req=1, starve_limit=8 -> 8 cycles of pipeline ownership, then 1 cycle with pipe_stall=1 and host granted, then host_ack; wait_cnt back to 0.
REQ-036 Write then read: host write 0x12345678 to 0x80, then read 0x80 -> the write ack has host_rdata=0; the read ack has host_rdata=0x12345678; mem_we=1 only in the write grant cycle.
REQ-037 Reset mid-access: rst=0 during the S_ACK cycle -> host_ack=0 at once; after release, state=S_PIPE and grant_count=0.
REQ-038 Wrap: force grant_count=0xFFFF, one host grant -> grant_count=0x0000.
REQ-039 Held request: host_req stays 1 across ack -> no grant in the S_ACK cycle; a new grant no earlier than the following cycle, per REQ-020.
